weight_buff: RTL and testbench
==============================

WEIGHT_BUFF -- requirements
Module: weight_buff

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the width of one weight word.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 16, giving the maximum number of stored weights.
REQ-003 SHALL have one clock and synchronous active-high reset: clk, rstn (reset asserted when rstn=1).
REQ-004 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-high reset.
- flush  in  1  single-cycle pulse that starts a weight load.
- kernel_size  in  8  kernel side length k.
- data_in  in  DATA_WIDTH  weight stream during load.
- en  in  1  single-cycle pulse that starts a read-out.
- data_out  out  DATA_WIDTH  registered weight output.
- pseudo_out  out  DATA_WIDTH  combinational peek of the entry at the read pointer.
- flush_BUSY  out  1  high while loading.
- read_VALID  out  1  high while data_out carries a valid weight.

Function
REQ-005 SHALL compute N = k*k (16-bit product), latched at flush acceptance; N is clamped to BUFFER_DEPTH; k=0 makes flush ignored.
REQ-006 SHALL implement FSM states IDLE, LOAD, READY, READ; after reset state is IDLE.
REQ-007 In IDLE or READY, flush=1 at edge E SHALL set state LOAD, flush_BUSY=1, write pointer 0.
REQ-008 In LOAD, each edge SHALL write data_in to mem[wr_ptr] and increment wr_ptr; on the Nth write the state SHALL become READY and flush_BUSY SHALL drop, so flush_BUSY is high for exactly N cycles.
REQ-009 flush or en during LOAD SHALL be ignored.
REQ-010 In READY, en=1 at edge E SHALL set state READ, data_out=mem[0], read_VALID=1 after E.
REQ-011 In READ, each edge SHALL advance to the next entry; after mem[N-1] has been presented for one cycle the state SHALL return to READY with read_VALID=0, so read_VALID is high for exactly N cycles.
REQ-012 en during READ SHALL be ignored; en in IDLE SHALL be ignored (read_VALID stays 0).
REQ-013 flush during READ SHALL abort the read (read_VALID=0 next cycle) and start LOAD as in REQ-007.
REQ-014 Stored weights SHALL be retained after a read; repeated en pulses in READY replay the same N words.
REQ-015 data_out SHALL hold its last value when read_VALID=0.
REQ-016 pseudo_out SHALL equal mem[rd_ptr] combinationally, where rd_ptr is 0 in IDLE, LOAD and READY and is the current entry in READ; it SHALL be 0 in IDLE.

Reset
REQ-017 rstn=1 at an edge SHALL force state IDLE, data_out=0, flush_BUSY=0, read_VALID=0, pointers 0, latched N=0; it overrides flush and en.
REQ-018 Reset mid-LOAD or mid-READ SHALL abort immediately; memory contents need not be cleared, but the buffer counts as empty.

Structure
REQ-019 A shared package SHALL hold the FSM state enum and the default DATA_WIDTH/BUFFER_DEPTH constants.
REQ-020 Storage SHALL be a sub-module weight_buff_mem (BUFFER_DEPTH x DATA_WIDTH, one synchronous write port, one asynchronous read port); the FSM and pointers live in weight_buff.
REQ-021 The stimulus source that streams data_in while flush_BUSY is high is verification-only and not part of this block.

Verification
REQ-022 Reset: rstn=1 for 2 cycles with flush=en=1 -> all outputs 0, flush_BUSY=0, read_VALID=0.
REQ-023 Load k=3: flush pulse, data_in=1..9 over the next 9 edges -> flush_BUSY high exactly 9 cycles, then 0.
REQ-024 Read: en pulse after REQ-023 -> read_VALID high 9 cycles, data_out=1,2,...,9 starting the cycle after en; a second en replays 1..9.
REQ-025 Clamp: k=5 with data_in=1..25 -> flush_BUSY high 16 cycles, read yields 1..16.
REQ-026 Abort: flush at 4th read cycle with k=2 and data_in=20..23 -> read_VALID=0 next cycle, flush_BUSY high 4 cycles, next read yields 20..23.
REQ-027 Ignored pulses: en in IDLE, flush/en during LOAD, k=0 flush -> no state change, read_VALID and flush_BUSY stay as before.

Source files
------------

// File: rtl/weight_buff_pkg.sv
`default_nettype none
// ============================================================================
// Module  : weight_buff_pkg
// Purpose : Shared types and default sizes for the weight buffer.
//           Holds the controller state encoding and the default
//           DATA_WIDTH / BUFFER_DEPTH values.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package weight_buff_pkg;

   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_BUFFER_DEPTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2,
      ST_READ  = 2'd3
   } state_t;

endpackage : weight_buff_pkg
`default_nettype wire

// File: rtl/weight_buff_mem.sv
`default_nettype none
// ============================================================================
// Module  : weight_buff_mem
// Purpose : BUFFER_DEPTH x DATA_WIDTH weight storage with one synchronous
//           write port and one asynchronous read port. Contents are not
//           reset.
// Ports   : clk      - clock, rising edge
//           we       - write enable
//           wr_addr  - write address
//           wr_data  - write data
//           rd_addr  - read address
//           rd_data  - read data (combinational)
// Rev     : 1.0  initial release
// ============================================================================
module weight_buff_mem
   import weight_buff_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
   parameter int ADDR_W       = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule : weight_buff_mem
`default_nettype wire

// File: rtl/weight_buff.sv
`default_nettype none
// ============================================================================
// Module  : weight_buff
// Purpose : Kernel weight buffer. A flush pulse loads k*k weights (clamped
//           to BUFFER_DEPTH) from data_in; an en pulse replays them on
//           data_out, one per cycle, with read_VALID high.
// Ports   : clk         - clock, rising edge
//           rstn        - synchronous active-high reset
//           flush       - pulse, starts a weight load
//           kernel_size - kernel side length k
//           data_in     - weight stream during load
//           en          - pulse, starts a read-out
//           data_out    - registered weight output
//           pseudo_out  - combinational view of the entry at the read pointer
//           flush_BUSY  - high while loading
//           read_VALID  - high while data_out carries a valid weight
// Rev     : 1.0  initial release
// ============================================================================
module weight_buff
   import weight_buff_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  flush,
   input  logic [7:0]            kernel_size,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [DATA_WIDTH-1:0] pseudo_out,
   output logic                  flush_BUSY,
   output logic                  read_VALID
);

   localparam int ADDR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int CNT_W  = $clog2(BUFFER_DEPTH + 1);

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  n_words;

   logic [15:0]           prod;
   logic [CNT_W-1:0]      n_new;
   logic [CNT_W-1:0]      n_last;
   logic                  flush_ok;
   logic                  wr_last;
   logic                  rd_last;
   logic [ADDR_W-1:0]     rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   assign prod     = 16'(kernel_size) * 16'(kernel_size);
   assign n_new    = (prod > 16'(BUFFER_DEPTH)) ? CNT_W'(BUFFER_DEPTH) : CNT_W'(prod);
   assign flush_ok = flush && (kernel_size != 8'd0);
   assign n_last   = n_words - CNT_W'(1);
   assign wr_last  = (CNT_W'(wr_ptr) == n_last);
   assign rd_last  = (CNT_W'(rd_ptr) == n_last);

   // The single read port looks one entry ahead while reading, so the next
   // data_out is ready at the edge. Outside READ it sits on entry 0, which
   // is what an en pulse presents first.
   assign rd_addr = (state == ST_READ) ? rd_ptr + ADDR_W'(1) : '0;

   // During READ data_out already holds mem[rd_ptr] (no writes happen while
   // reading), so it stands in for the peek; otherwise rd_ptr is 0 and the
   // port is addressing entry 0.
   assign pseudo_out = (state == ST_IDLE) ? '0 :
                       (state == ST_READ) ? data_out : rd_data;

   weight_buff_mem #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BUFFER_DEPTH (BUFFER_DEPTH),
      .ADDR_W       (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we      (state == ST_LOAD),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rstn) begin
         state      <= ST_IDLE;
         data_out   <= '0;
         flush_BUSY <= 1'b0;
         read_VALID <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         n_words    <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_READY: begin
               if (flush_ok) begin
                  state      <= ST_LOAD;
                  flush_BUSY <= 1'b1;
                  wr_ptr     <= '0;
                  n_words    <= n_new;
               end else if ((state == ST_READY) && en) begin
                  state      <= ST_READ;
                  read_VALID <= 1'b1;
                  data_out   <= rd_data;
                  rd_ptr     <= '0;
               end
            end
            ST_LOAD: begin
               if (wr_last) begin
                  state      <= ST_READY;
                  flush_BUSY <= 1'b0;
                  wr_ptr     <= '0;
               end else begin
                  wr_ptr <= wr_ptr + ADDR_W'(1);
               end
            end
            ST_READ: begin
               if (flush_ok) begin
                  // Abort the read and reload; data_out keeps its last value.
                  state      <= ST_LOAD;
                  read_VALID <= 1'b0;
                  flush_BUSY <= 1'b1;
                  wr_ptr     <= '0;
                  rd_ptr     <= '0;
                  n_words    <= n_new;
               end else if (rd_last) begin
                  state      <= ST_READY;
                  read_VALID <= 1'b0;
                  rd_ptr     <= '0;
               end else begin
                  rd_ptr   <= rd_ptr + ADDR_W'(1);
                  data_out <= rd_data;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule : weight_buff
`default_nettype wire

// File: tb/tb_weight_buff.sv
`default_nettype none
// ============================================================================
// Module  : tb_weight_buff
// Purpose : Directed self-checking bench for weight_buff.
// Rev     : 1.0  initial release
// ============================================================================
module tb_weight_buff;

   logic        clk = 1'b0;
   logic        rstn;
   logic        flush;
   logic [7:0]  kernel_size;
   logic [15:0] data_in;
   logic        en;
   logic [15:0] data_out;
   logic [15:0] pseudo_out;
   logic        flush_BUSY;
   logic        read_VALID;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   weight_buff #(
      .DATA_WIDTH   (16),
      .BUFFER_DEPTH (16)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .flush       (flush),
      .kernel_size (kernel_size),
      .data_in     (data_in),
      .en          (en),
      .data_out    (data_out),
      .pseudo_out  (pseudo_out),
      .flush_BUSY  (flush_BUSY),
      .read_VALID  (read_VALID)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Flush with side k, stream count words base.., expect busy for exp_n writes.
   // A flush/en pair is injected mid-load and must have no effect.
   task automatic load(input int k, input int count, input int base, input int exp_n);
      flush = 1'b1;
      kernel_size = 8'(k);
      tick();
      flush = 1'b0;
      chk("load_busy_start", 32'(flush_BUSY), 1);
      for (int i = 0; i < count; i++) begin
         data_in = 16'(base + i);
         if (i == 1) begin
            flush = 1'b1;
            en    = 1'b1;
         end
         tick();
         flush = 1'b0;
         en    = 1'b0;
         chk("load_busy", 32'(flush_BUSY), (i < exp_n - 1) ? 1 : 0);
         chk("load_valid", 32'(read_VALID), 0);
      end
   endtask

   // Pulse en and expect n words base..base+n-1; en mid-read is ignored.
   task automatic read_expect(input int n, input int base);
      en = 1'b1;
      tick();
      en = 1'b0;
      for (int j = 0; j < n; j++) begin
         chk("read_valid", 32'(read_VALID), 1);
         chk("read_data", 32'(data_out), 32'(base + j));
         chk("read_peek", 32'(pseudo_out), 32'(base + j));
         if (j == 2) en = 1'b1;
         tick();
         en = 1'b0;
      end
      chk("read_end_valid", 32'(read_VALID), 0);
      chk("read_hold", 32'(data_out), 32'(base + n - 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b1; flush = 1'b1; en = 1'b1; kernel_size = 8'd3; data_in = 16'd7;
      tick();
      tick();
      chk("rst_data", 32'(data_out), 0);
      chk("rst_peek", 32'(pseudo_out), 0);
      chk("rst_busy", 32'(flush_BUSY), 0);
      chk("rst_valid", 32'(read_VALID), 0);
      rstn = 1'b0; flush = 1'b0; en = 1'b0;

      // en in IDLE and a k=0 flush do nothing
      en = 1'b1;
      tick();
      en = 1'b0;
      chk("idle_en_valid", 32'(read_VALID), 0);
      kernel_size = 8'd0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("k0_idle_busy", 32'(flush_BUSY), 0);
      tick();
      chk("k0_idle_valid", 32'(read_VALID), 0);

      // k=3 load of 1..9, then two reads
      load(3, 9, 1, 9);
      chk("ready_peek", 32'(pseudo_out), 1);
      read_expect(9, 1);
      read_expect(9, 1);

      // k=0 flush in READY is ignored; contents and N retained
      kernel_size = 8'd0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("k0_ready_busy", 32'(flush_BUSY), 0);
      read_expect(9, 1);

      // k=5 clamps to 16 words
      load(5, 25, 1, 16);
      read_expect(16, 1);

      // abort at the 4th read cycle with a k=2 reload
      en = 1'b1;
      tick();
      en = 1'b0;
      for (int j = 0; j < 3; j++) begin
         chk("abort_pre_data", 32'(data_out), 32'(j + 1));
         tick();
      end
      chk("abort_4th_data", 32'(data_out), 4);
      chk("abort_4th_valid", 32'(read_VALID), 1);
      flush = 1'b1;
      kernel_size = 8'd2;
      tick();
      flush = 1'b0;
      chk("abort_valid", 32'(read_VALID), 0);
      chk("abort_busy", 32'(flush_BUSY), 1);
      chk("abort_hold", 32'(data_out), 4);
      for (int i = 0; i < 4; i++) begin
         data_in = 16'(20 + i);
         tick();
         chk("abort_load_busy", 32'(flush_BUSY), (i < 3) ? 1 : 0);
      end
      read_expect(4, 20);

      // reset mid-read empties the buffer
      en = 1'b1;
      tick();
      en = 1'b0;
      chk("pre_rst_valid", 32'(read_VALID), 1);
      rstn = 1'b1;
      tick();
      rstn = 1'b0;
      chk("midrst_valid", 32'(read_VALID), 0);
      chk("midrst_data", 32'(data_out), 0);
      chk("midrst_peek", 32'(pseudo_out), 0);
      en = 1'b1;
      tick();
      en = 1'b0;
      chk("post_rst_en_valid", 32'(read_VALID), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_weight_buff
`default_nettype wire
